// File: rtl/upstream_order_limiter.sv
// rtl/upstream_order_limiter.sv - per-client order accumulator with trade-limit accept/reject and clear sweep
// Optional macro UPSTREAM_STATS_EN adds saturating accept/reject counters.
module upstream_order_limiter #(
  parameter int N_CLIENTS = 32,
  parameter int ID_W      = 5,
  parameter int AMT_W     = 32,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_max,
  input  logic             new_order,
  input  logic [ID_W-1:0]  client_id,
  input  logic [AMT_W-1:0] amount,
  input  logic             clear_all,
  output logic [ACC_W-1:0] accumulated_orders,
  output logic [ACC_W-1:0] max_to_trade,
  output logic             thenewmax,
  output logic             order_accepted,
  output logic             order_rejected,
`ifdef UPSTREAM_STATS_EN
  output logic             busy,
  output logic [ACC_W-1:0] total_accepted,
  output logic [ACC_W-1:0] total_rejected
`else
  output logic             busy
`endif
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_idx;
  logic [ACC_W-1:0] r_acc   [N_CLIENTS];
  logic [ACC_W-1:0] r_limit [N_CLIENTS];
  logic [ACC_W-1:0] r_acc_out;
  logic [ACC_W-1:0] r_head_out;
  logic             r_newmax;
  logic             r_accepted;
  logic             r_rejected;
  logic             r_busy;

  logic             w_id_valid;
  logic             w_idle;
  logic [ACC_W-1:0] w_amt_ext;
  logic [ACC_W-1:0] w_acc_cur;
  logic [ACC_W-1:0] w_lim_cur;
  logic [ACC_W-1:0] w_lim_eff;
  logic [ACC_W:0]   w_sum;
  logic             w_fits;
  logic             w_do_max;
  logic             w_do_order;
  logic             w_accept;
  logic             w_reject;
  logic [ACC_W-1:0] w_acc_new;
  logic [ACC_W-1:0] w_head;
  logic             w_show;

  assign w_id_valid = ({1'b0, client_id} < (ID_W+1)'(N_CLIENTS));
  assign w_idle     = (r_state == ST_IDLE);
  assign w_amt_ext  = ACC_W'(amount);
  assign w_acc_cur  = w_id_valid ? r_acc[client_id]   : '0;
  assign w_lim_cur  = w_id_valid ? r_limit[client_id] : '0;

  // A same-cycle limit load takes effect before the order is checked.
  assign w_do_max   = new_max & w_idle & w_id_valid;
  assign w_lim_eff  = w_do_max ? w_amt_ext : w_lim_cur;
  assign w_sum      = {1'b0, w_acc_cur} + {1'b0, w_amt_ext};
  assign w_fits     = ~w_sum[ACC_W] & (w_sum[ACC_W-1:0] <= w_lim_eff);
  assign w_do_order = new_order & w_idle & w_id_valid;
  assign w_accept   = w_do_order & ((amount == '0) | w_fits);
  assign w_reject   = new_order & ~w_accept;
  assign w_acc_new  = w_accept ? w_sum[ACC_W-1:0] : w_acc_cur;
  assign w_head     = (w_lim_eff > w_acc_new) ? (w_lim_eff - w_acc_new) : '0;
  assign w_show     = w_do_max | w_do_order;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_acc_out  <= '0;
      r_head_out <= '0;
      r_newmax   <= 1'b0;
      r_accepted <= 1'b0;
      r_rejected <= 1'b0;
      r_busy     <= 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) begin
        r_acc[i]   <= '0;
        r_limit[i] <= '0;
      end
    end else begin
      r_newmax   <= w_do_max;
      r_accepted <= w_accept;
      r_rejected <= w_reject;
      if (w_do_max) r_limit[client_id] <= w_amt_ext;
      if (w_accept) r_acc[client_id]   <= w_acc_new;
      if (w_show) begin
        r_acc_out  <= w_acc_new;
        r_head_out <= w_head;
      end
      case (r_state)
        ST_IDLE: begin
          if (clear_all) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Requests are blocked in this state, so the sweep owns the accumulators.
          r_acc[r_idx] <= '0;
          if (r_idx == ID_W'(N_CLIENTS - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign accumulated_orders = r_acc_out;
  assign max_to_trade       = r_head_out;
  assign thenewmax          = r_newmax;
  assign order_accepted     = r_accepted;
  assign order_rejected     = r_rejected;
  assign busy               = r_busy;

`ifdef UPSTREAM_STATS_EN
  logic [ACC_W-1:0] r_tot_acc;
  logic [ACC_W-1:0] r_tot_rej;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tot_acc <= '0;
      r_tot_rej <= '0;
    end else begin
      if (r_accepted && (r_tot_acc != '1)) r_tot_acc <= r_tot_acc + 1'b1;
      if (r_rejected && (r_tot_rej != '1)) r_tot_rej <= r_tot_rej + 1'b1;
    end
  end

  assign total_accepted = r_tot_acc;
  assign total_rejected = r_tot_rej;
`endif

endmodule

// File: tb/tb_upstream_order_limiter.sv
// tb/tb_upstream_order_limiter.sv - model-checked directed bench for upstream_order_limiter
module tb_upstream_order_limiter;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_max = 1'b0;
  logic        new_order = 1'b0;
  logic [4:0]  client_id = '0;
  logic [31:0] amount = '0;
  logic        clear_all = 1'b0;
  logic [31:0] accumulated_orders;
  logic [31:0] max_to_trade;
  logic        thenewmax;
  logic        order_accepted;
  logic        order_rejected;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  upstream_order_limiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .new_max            (new_max),
    .new_order          (new_order),
    .client_id          (client_id),
    .amount             (amount),
    .clear_all          (clear_all),
    .accumulated_orders (accumulated_orders),
    .max_to_trade       (max_to_trade),
    .thenewmax          (thenewmax),
    .order_accepted     (order_accepted),
    .order_rejected     (order_rejected),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: plain integer arithmetic; a clear is modelled as an instant wipe plus an N-cycle busy window.
  longint m_acc [N];
  longint m_lim [N];
  int     m_busy_cnt = 0;
  longint e_acc = 0, e_head = 0;
  bit     e_newmax = 0, e_accp = 0, e_rej = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_acc[i] = 0; m_lim[i] = 0; end
      m_busy_cnt = 0;
      e_acc = 0; e_head = 0; e_newmax = 0; e_accp = 0; e_rej = 0;
    end else begin
      longint s;
      int id;
      id = int'(client_id);
      e_newmax = 0; e_accp = 0; e_rej = 0;
      if (m_busy_cnt == 0 && id < N) begin
        if (new_max) begin m_lim[id] = longint'(amount); e_newmax = 1; end
        if (new_order) begin
          s = m_acc[id] + longint'(amount);
          if (amount == 0 || s <= m_lim[id]) begin m_acc[id] = s; e_accp = 1; end
          else e_rej = 1;
        end
        if (new_max || new_order) begin
          e_acc  = m_acc[id];
          e_head = (m_lim[id] > m_acc[id]) ? m_lim[id] - m_acc[id] : 0;
        end
      end else if (new_order) begin
        e_rej = 1;
      end
      if (m_busy_cnt > 0) m_busy_cnt--;
      else if (clear_all) begin
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        m_busy_cnt = N;
      end
    end
  end

  always @(negedge clk) begin
    chk("acc_model",  64'(accumulated_orders), 64'(e_acc));
    chk("head_model", 64'(max_to_trade), 64'(e_head));
    chk("newmax_model", 64'(thenewmax), 64'(e_newmax));
    chk("accept_model", 64'(order_accepted), 64'(e_accp));
    chk("reject_model", 64'(order_rejected), 64'(e_rej));
    chk("busy_model", 64'(busy), 64'(m_busy_cnt > 0));
  end

  task automatic req(input logic mx, input logic od, input logic [4:0] id,
                     input logic [31:0] amt, input logic clr);
    new_max = mx; new_order = od; client_id = id; amount = amt; clear_all = clr;
    @(posedge clk); #2;
    new_max = 0; new_order = 0; client_id = '0; amount = '0; clear_all = 0;
  endtask

  initial begin
    int bcnt;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_acc", 64'(accumulated_orders), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    req(1, 0, 5'd3, 32'd100, 0);
    chk("max3_pulse", 64'(thenewmax), 64'd1);
    chk("max3_head", 64'(max_to_trade), 64'd100);
    req(0, 1, 5'd3, 32'd60, 0);
    chk("ord60_acc", 64'(accumulated_orders), 64'd60);
    chk("ord60_head", 64'(max_to_trade), 64'd40);
    req(0, 1, 5'd3, 32'd40, 0);
    chk("fill_accept", 64'(order_accepted), 64'd1);
    chk("fill_acc", 64'(accumulated_orders), 64'd100);
    chk("fill_head", 64'(max_to_trade), 64'd0);
    req(0, 1, 5'd3, 32'd1, 0);
    chk("over_reject", 64'(order_rejected), 64'd1);
    chk("over_acc", 64'(accumulated_orders), 64'd100);
    req(0, 1, 5'd3, 32'd0, 0);
    chk("zero_accept", 64'(order_accepted), 64'd1);

    req(1, 1, 5'd7, 32'd50, 0);
    chk("same_newmax", 64'(thenewmax), 64'd1);
    chk("same_accept", 64'(order_accepted), 64'd1);
    chk("same_acc", 64'(accumulated_orders), 64'd50);
    chk("same_head", 64'(max_to_trade), 64'd0);

    req(1, 0, 5'd1, 32'hFFFF_FFFF, 0);
    req(0, 1, 5'd1, 32'hFFFF_FFF0, 0);
    chk("ovf_first", 64'(order_accepted), 64'd1);
    req(0, 1, 5'd1, 32'h20, 0);
    chk("ovf_reject", 64'(order_rejected), 64'd1);
    chk("ovf_acc", 64'(accumulated_orders), 64'hFFFF_FFF0);
    chk("ovf_head", 64'(max_to_trade), 64'hF);

    req(1, 0, 5'd3, 32'd50, 0);
    chk("lower_head", 64'(max_to_trade), 64'd0);
    chk("lower_acc", 64'(accumulated_orders), 64'd100);
    req(0, 1, 5'd3, 32'd5, 0);
    chk("lower_reject", 64'(order_rejected), 64'd1);
    req(0, 0, 5'd0, 32'd0, 0);
    chk("idle_hold", 64'(accumulated_orders), 64'd100);

    req(1, 0, 5'd2, 32'd20, 0);
    req(0, 1, 5'd2, 32'd5, 1);
    chk("clr_edge_accept", 64'(order_accepted), 64'd1);
    bcnt = int'(busy);
    req(0, 1, 5'd2, 32'd10, 0);
    chk("clr_order_reject", 64'(order_rejected), 64'd1);
    bcnt += int'(busy);
    req(1, 0, 5'd5, 32'd77, 0);
    chk("clr_max_dropped", 64'(thenewmax), 64'd0);
    bcnt += int'(busy);
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #2;
      bcnt += int'(busy);
    end
    chk("busy_cycles", 64'(bcnt), 64'd32);
    req(0, 1, 5'd3, 32'd1, 0);
    chk("post_clr3_accept", 64'(order_accepted), 64'd1);
    chk("post_clr3_acc", 64'(accumulated_orders), 64'd1);
    chk("post_clr3_head", 64'(max_to_trade), 64'd49);
    req(0, 1, 5'd2, 32'd10, 0);
    chk("post_clr2_accept", 64'(order_accepted), 64'd1);
    chk("post_clr2_acc", 64'(accumulated_orders), 64'd10);
    req(0, 1, 5'd5, 32'd0, 0);
    chk("max5_unchanged", 64'(max_to_trade), 64'd0);

    req(1, 0, 5'd4, 32'd30, 0);
    req(0, 1, 5'd4, 32'd3, 0);
    req(0, 0, 5'd0, 32'd0, 1);
    repeat (9) begin @(posedge clk); #2; end
    chk("mid_sweep_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acc", 64'(accumulated_orders), 64'd0);
    chk("rst_head", 64'(max_to_trade), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    req(0, 1, 5'd4, 32'd5, 0);
    chk("post_rst_reject", 64'(order_rejected), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);

    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/upstream_order_limiter.md
Name: upstream_order_limiter

Overview:
- Parametrised next-generation upstream processor.
- Keeps a per-client accumulated order total and a per-client trade limit, and accepts or rejects each order against that client's limit.
- Sits between the order-entry GPIO front end and the downstream trade engine.
- Adds to the single-client upstream block: N clients, configurable widths, explicit accept/reject, overflow protection and a multi-cycle clear sweep.

Parameters:
- N_CLIENTS, 32, number of tracked clients.
- ID_W, 5, client_id width; N_CLIENTS must be at most 2**ID_W.
- AMT_W, 32, width of the order and limit amount.
- ACC_W, 32, width of the per-client accumulator; ACC_W >= AMT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- new_max  in  1  load a new limit for client_id from amount.
- new_order  in  1  order request of amount for client_id.
- client_id  in  ID_W  addressed client.
- amount  in  AMT_W  order size or new limit value.
- clear_all  in  1  start the sweep that zeroes all accumulators; limits are kept.
- accumulated_orders  out  ACC_W  accumulator of the last addressed client, after update.
- max_to_trade  out  ACC_W  headroom of that client: limit − accumulated, floored at 0.
- thenewmax  out  1  one-cycle pulse, limit updated.
- order_accepted  out  1  one-cycle pulse.
- order_rejected  out  1  one-cycle pulse.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Async reset while rst_n=0:
  - all accumulators and limits go to 0;
  - all outputs go to 0;
  - FSM goes to IDLE.
- Reset asserted mid-sweep aborts the sweep. After release the block starts in IDLE with everything zeroed.
- Inputs are sampled on the rising edge of clk. All outputs are registered and reflect an edge-N request at edge N+1 (latency 1).
- FSM states: IDLE and CLEAR.
  - IDLE → CLEAR when clear_all=1. busy rises next cycle.
  - In CLEAR, the sweep index zeroes one accumulator per cycle, from 0 up to N_CLIENTS−1.
  - CLEAR → IDLE after index N_CLIENTS−1 is written. busy is high for exactly N_CLIENTS cycles.
  - clear_all while in CLEAR is ignored.
- Requests during CLEAR (state register = CLEAR):
  - new_order produces order_rejected.
  - new_max is dropped: no thenewmax pulse, limit unchanged.
  - The clear_all edge itself (state still IDLE) processes a same-cycle request normally. That client's accumulator is zeroed later by the sweep.
- Limit load (new_max=1, IDLE):
  - limit[id] ← amount, zero-extended to ACC_W.
  - thenewmax pulses.
  - Outputs show the client's accumulator and its new headroom.
- Order (new_order=1, IDLE):
  - sum = acc[id] + amount, computed at ACC_W+1 bits.
  - Accept when the sum carry is 0 and sum ≤ limit[id]. On accept, acc[id] ← sum and order_accepted pulses.
  - Otherwise reject: acc unchanged, order_rejected pulses.
  - amount=0 is always accepted with no change.
  - Exact fill (sum = limit) is accepted; headroom becomes 0.
- Simultaneous new_max and new_order for the same client: the limit is written first and the order is checked against the new limit. Both pulses fire.
- Invalid client (client_id ≥ N_CLIENTS):
  - any order is rejected;
  - any new_max is dropped;
  - accumulated_orders and max_to_trade hold their previous values.
- Limit lowered below the accumulator: the accumulator is not modified, max_to_trade reads 0, and further nonzero orders are rejected.
- When no request is present, accumulated_orders and max_to_trade hold their values; the pulse outputs are 0.

Optional Feature:
- Macro: UPSTREAM_STATS_EN.
- Defined:
  - adds outputs total_accepted and total_rejected, ACC_W each;
  - the counters increment on the corresponding pulse and saturate at all-ones;
  - reset clears them; clear_all does not.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Set limit and fill exactly: new_max id=3 amt=100; order id=3 amt=60; order id=3 amt=40 → accepted ×2, accumulated_orders=100, max_to_trade=0.
- Over-limit order: limit id=3 is 100 with acc=100; order amt=1 → order_rejected=1, acc stays 100.
- Same-cycle limit and order: id=7, new_max amt=50 and new_order amt=50 together → thenewmax=1, order_accepted=1, acc=50, max_to_trade=0.
- Overflow guard: limit id=1 = 0xFFFFFFFF; order 0xFFFFFFF0 then order 0x20 → first accepted, second rejected (carry), acc=0xFFFFFFF0.
- Clear sweep: pulse clear_all, then order id=2 one cycle later → busy high for 32 cycles, order rejected; after busy falls every acc=0, limits intact, order id=2 amt=10 accepted.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 10 → all outputs 0 and busy=0 immediately; after release an order with limit 0 is rejected.
